// File: rtl/lmul_pkg.sv
// Shared types and constants for the L-Mul score accumulator.
// BF16 field layout, fixed-point score format, FSM states.
package lmul_pkg;

  localparam int BF16_WIDTH    = 16;
  localparam int BF16_SIGN_POS = 15;
  localparam int BF16_EXP_LSB  = 7;
  localparam int BF16_EXP_W    = 8;
  localparam int BF16_MAN_W    = 7;
  localparam int BF16_EXP_BIAS = 127;

  localparam int ACC_W = 32;
  localparam int FRAC  = 16;

  typedef logic signed [ACC_W-1:0] score_t;

  typedef enum logic [1:0] {
    ACCUM,
    ARGMAX,
    DONE
  } state_e;

  localparam score_t ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam score_t ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

endpackage

// File: rtl/bf16_to_fixed.sv
// Combinational bf16 -> signed Q(ACC_W-FRAC).FRAC converter.
// Zero/denormal -> 0, inf/NaN and overflow saturate, right shifts truncate.
module bf16_to_fixed
  import lmul_pkg::*;
(
  input  logic [BF16_WIDTH-1:0] bf_i,
  output score_t                fx_o
);

  localparam int LSH_W = $clog2(ACC_W);
  localparam logic signed [9:0] SH_OFF =
    10'(BF16_EXP_BIAS - FRAC + BF16_MAN_W);
  localparam logic signed [9:0] SH_SAT =
    10'(ACC_W - BF16_MAN_W - 1);
  localparam logic signed [9:0] SH_RMIN =
    -10'sd8;

  logic                  sgn;
  logic [BF16_EXP_W-1:0] ex;
  logic [BF16_MAN_W:0]   man;
  logic signed [9:0]     sh;
  logic [9:0]            nsh;
  score_t                mag;

  // Decode fields, align mantissa to the score's binary point, apply sign.
  always_comb begin
    sgn = bf_i[BF16_SIGN_POS];
    ex  = bf_i[BF16_EXP_LSB +: BF16_EXP_W];
    man = {1'b1, bf_i[BF16_MAN_W-1:0]};
    sh  = $signed({2'b00, ex}) - SH_OFF;
    nsh = 10'(-sh);
    mag = '0;
    if (ex == '0) begin
      mag = '0;
    end else if (ex == '1) begin
      mag = ACC_MAX;
    end else if (sh >= SH_SAT) begin
      mag = ACC_MAX;
    end else if (sh >= 10'sd0) begin
      mag = $signed({{(ACC_W-BF16_MAN_W-1){1'b0}}, man}
                    << sh[LSH_W-1:0]);
    end else if (sh > SH_RMIN) begin
      mag = $signed({{(ACC_W-BF16_MAN_W-1){1'b0}},
                     man >> nsh[2:0]});
    end
    fx_o = sgn ? -mag : mag;
  end

endmodule

// File: rtl/lmul_score_accum.sv
// Sums bf16 products into per-class scores, then argmax -> valid/ready.
// Define LMUL_ACC_SAT_EN for saturating score adds (default: wrap).
module lmul_score_accum
  import lmul_pkg::*;
#(
  parameter  int N     = 28,
  parameter  int M     = 10,
  localparam int CLS_W = (M > 1) ? $clog2(M) : 1,
  localparam int ELM_W = (N*N > 1) ? $clog2(N*N) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [BF16_WIDTH-1:0] i_p,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [CLS_W-1:0]      o_class,
  output logic [ACC_W-1:0]      o_score,
  output logic                  o_busy
);

  localparam logic [CLS_W-1:0] CLS_LAST = CLS_W'(M-1);
  localparam logic [ELM_W-1:0] ELM_LAST = ELM_W'(N*N-1);

  state_e           state_q, state_d;
  logic [ELM_W-1:0] elem_q;
  logic [CLS_W-1:0] cls_q;
  logic             last_q;
  logic             busy_q;
  score_t           conv_d, conv_q;
  logic             add_v_q;
  logic [CLS_W-1:0] add_cls_q;
  score_t           score_q [M];
  logic [CLS_W-1:0] scan_q;
  score_t           best_q;
  logic [CLS_W-1:0] best_idx_q;

  logic accept, hs, last_acc, start_scan;

  function automatic score_t acc_add(score_t a, score_t b);
`ifdef LMUL_ACC_SAT_EN
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? ACC_MIN : ACC_MAX;
    return s[ACC_W-1:0];
`else
    return a + b;
`endif
  endfunction

  assign accept     = i_valid & i_ready;
  assign hs         = o_valid & o_ready;
  assign last_acc   = accept & (cls_q == CLS_LAST)
                    & (elem_q == ELM_LAST);
  assign start_scan = (state_q == ACCUM) & (state_d == ARGMAX);

  bf16_to_fixed u_cvt (
    .bf_i (i_p),
    .fx_o (conv_d)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  // FSM next state: leave ACCUM only after the final add has landed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:   if (last_q && !add_v_q) state_d = ARGMAX;
      ARGMAX:  if (scan_q == CLS_LAST) state_d = DONE;
      DONE:    if (o_ready)            state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // FSM outputs.
  always_comb begin
    i_ready = (state_q == ACCUM) && !last_q;
    o_valid = (state_q == DONE);
    o_busy  = busy_q;
  end

  assign o_class = best_idx_q;
  assign o_score = best_q;

  // Product position counters and frame-complete / busy flags.
  always_ff @(posedge clk) begin
    if (rst || hs) begin
      elem_q <= '0;
      cls_q  <= '0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
    end else if (accept) begin
      busy_q <= 1'b1;
      if (last_acc) begin
        elem_q <= '0;
        cls_q  <= '0;
        last_q <= 1'b1;
      end else if (elem_q == ELM_LAST) begin
        elem_q <= '0;
        cls_q  <= cls_q + 1'b1;
      end else begin
        elem_q <= elem_q + 1'b1;
      end
    end
  end

  // Register the converted product together with its class tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      add_v_q   <= 1'b0;
      conv_q    <= '0;
      add_cls_q <= '0;
    end else begin
      add_v_q <= accept;
      if (accept) begin
        conv_q    <= conv_d;
        add_cls_q <= cls_q;
      end
    end
  end

  // Per-class score accumulation.
  always_ff @(posedge clk) begin
    if (rst || hs) begin
      for (int i = 0; i < M; i++) score_q[i] <= '0;
    end else if (add_v_q) begin
      score_q[add_cls_q] <= acc_add(score_q[add_cls_q], conv_q);
    end
  end

  // Sequential argmax; strict compare keeps the lowest index on ties.
  always_ff @(posedge clk) begin
    if (rst || hs) begin
      scan_q     <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
    end else if (start_scan) begin
      scan_q     <= '0;
      best_q     <= ACC_MIN;
      best_idx_q <= '0;
    end else if (state_q == ARGMAX) begin
      if (score_q[scan_q] > best_q) begin
        best_q     <= score_q[scan_q];
        best_idx_q <= scan_q;
      end
      if (scan_q != CLS_LAST) scan_q <= scan_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_lmul_score_accum.sv
// Randomized bench for lmul_score_accum (N=2, M=3) with a real-valued
// reference model of conversion, accumulation and argmax.
module tb_lmul_score_accum;

  localparam int N  = 2;
  localparam int M  = 3;
  localparam int NN = N * N;
  localparam int CW = 2;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          o_ready = 1'b0;
  logic [15:0]   i_p = '0;
  logic          i_ready, o_valid, o_busy;
  logic [CW-1:0] o_class;
  logic [31:0]   o_score;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc = -1000;
  logic prev_v = 1'b0;
  bit exp_on = 1'b0;
  int exp_cls = 0;
  logic [31:0] exp_sc = '0;
  logic [15:0] frm[$];

  lmul_score_accum #(.N(N), .M(M)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_p     (i_p),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_class (o_class),
    .o_score (o_score),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // value = (-1)^s * (1 + m/128) * 2^(e-127) * 2^16, truncated, clamped
  function automatic longint cvt(logic [15:0] p);
    int e;
    real r;
    longint mag;
    e = int'(p[14:7]);
    if (e == 0) return 0;
    if (e == 255) begin
      mag = MAXV;
    end else begin
      r = 1.0 + real'(p[6:0]) / 128.0;
      r = r * 65536.0;
      for (int k = 0; k < e - 127; k++) r = r * 2.0;
      for (int k = 0; k < 127 - e; k++) r = r / 2.0;
      if (r > 2147483647.0) mag = MAXV;
      else mag = longint'($rtoi(r));
    end
    return p[15] ? -mag : mag;
  endfunction

  function automatic longint addm(longint a, longint b);
    longint s;
    s = a + b;
`ifdef LMUL_ACC_SAT_EN
    if (s > MAXV) s = MAXV;
    if (s < MINV) s = MINV;
`else
    s = longint'(int'(s));
`endif
    return s;
  endfunction

  task automatic model();
    longint sc[M];
    int b;
    for (int c = 0; c < M; c++) sc[c] = 0;
    foreach (frm[i]) sc[i / NN] = addm(sc[i / NN], cvt(frm[i]));
    b = 0;
    for (int c = 1; c < M; c++) if (sc[c] > sc[b]) b = c;
    exp_cls = b;
    exp_sc  = 32'(sc[b]);
    exp_on  = 1'b1;
  endtask

  // Acceptance edge index, counted in rising edges.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && i_valid && i_ready) last_acc <= cyc + 1;
  end

  // Every-cycle result compare against the model.
  always @(negedge clk) begin
    if (!rst && o_valid) begin
      if (!prev_v) chk("latency", 64'(cyc), 64'(last_acc + M + 2));
      if (exp_on) begin
        chk("class", 64'(o_class), 64'(exp_cls));
        chk("score", 64'(o_score), 64'(exp_sc));
      end
      chk("iready_low_in_result", 64'(i_ready), 64'd0);
    end
    prev_v <= o_valid && !rst;
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_valid = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic chk_idle(string nm);
    chk({nm, "_i_ready"}, 64'(i_ready), 64'd1);
    chk({nm, "_o_valid"}, 64'(o_valid), 64'd0);
    chk({nm, "_o_busy"}, 64'(o_busy), 64'd0);
  endtask

  task automatic build(logic [15:0] p0, logic [15:0] p1, logic [15:0] p2);
    frm.delete();
    for (int k = 0; k < NN; k++) frm.push_back(p0);
    for (int k = 0; k < NN; k++) frm.push_back(p1);
    for (int k = 0; k < NN; k++) frm.push_back(p2);
  endtask

  function automatic logic [15:0] rnd_bf16();
    int sel, e;
    sel = int'($urandom_range(0, 9));
    if (sel == 0) e = 0;
    else if (sel == 1) e = 255;
    else e = int'($urandom_range(95, 145));
    return {1'($urandom), 8'(e), 7'($urandom)};
  endfunction

  task automatic send_frame(int maxgap);
    int t;
    foreach (frm[i]) begin
      i_valid = 1'b0;
      if (maxgap > 0) begin
        i_p = 16'($urandom);
        tick(int'($urandom_range(0, maxgap)));
      end
      t = 0;
      while (!i_ready && t < 100) begin
        tick(1);
        t++;
      end
      if (!i_ready) chk("i_ready_timeout", 64'(i_ready), 64'd1);
      i_valid = 1'b1;
      i_p = frm[i];
      tick(1);
    end
    i_valid = 1'b0;
    i_p = 16'($urandom);
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!o_valid && t < 100) begin
      tick(1);
      t++;
    end
    chk("o_valid_seen", 64'(o_valid), 64'd1);
  endtask

  task automatic finish_hs();
    o_ready = 1'b1;
    tick(1);
    chk_idle("after_hs");
    o_ready = 1'b0;
  endtask

  initial begin
    tick(1);
    do_reset();
    chk_idle("reset");
    chk("reset_class", 64'(o_class), 64'd0);
    chk("reset_score", 64'(o_score), 64'd0);

    chk("model_1p0", 64'(cvt(16'h3F80)), 64'h10000);
    chk("model_m1p0", 64'(cvt(16'hBF80)), 64'(-64'sd65536));
    chk("model_inf", 64'(cvt(16'h7F80)), 64'h7FFFFFFF);

    build(16'h3F80, 16'h4000, 16'hBF80);
    model();
    o_ready = 1'b1;
    send_frame(0);
    wait_valid();
    chk("s1_class", 64'(o_class), 64'd1);
    chk("s1_score", 64'(o_score), 64'h00080000);
    chk("s1_busy", 64'(o_busy), 64'd1);
    tick(1);
    chk_idle("s1_hs");
    o_ready = 1'b0;

    build(16'h3F00, 16'h0000, 16'h3F00);
    model();
    send_frame(0);
    wait_valid();
    chk("tie_class", 64'(o_class), 64'd0);
    chk("tie_score", 64'(o_score), 64'h00020000);
    for (int k = 0; k < 20; k++) begin
      tick(1);
      chk("bp_ready", 64'(i_ready), 64'd0);
      chk("bp_valid", 64'(o_valid), 64'd1);
      chk("bp_class", 64'(o_class), 64'd0);
      chk("bp_score", 64'(o_score), 64'h00020000);
    end
    finish_hs();

    build(16'h3F80, 16'h4000, 16'hBF80);
    model();
    send_frame(3);
    wait_valid();
    chk("bub_class", 64'(o_class), 64'd1);
    chk("bub_score", 64'(o_score), 64'h00080000);
    finish_hs();

    build(16'h7F80, 16'h0000, 16'h0000);
    model();
    send_frame(1);
    wait_valid();
`ifdef LMUL_ACC_SAT_EN
    chk("sat_class", 64'(o_class), 64'd0);
    chk("sat_score", 64'(o_score), 64'h7FFFFFFF);
`else
    chk("wrap_class", 64'(o_class), 64'd1);
    chk("wrap_score", 64'(o_score), 64'd0);
`endif
    finish_hs();

    exp_on = 1'b0;
    frm.delete();
    for (int k = 0; k < 6; k++) frm.push_back(16'h4100);
    send_frame(1);
    do_reset();
    chk_idle("midrst");
    build(16'h0000, 16'h0000, 16'h4040);
    model();
    send_frame(0);
    wait_valid();
    chk("midrst_class", 64'(o_class), 64'd2);
    chk("midrst_score", 64'(o_score), 64'h000C0000);
    finish_hs();

    for (int f = 0; f < 15; f++) begin
      frm.delete();
      for (int k = 0; k < M * NN; k++) frm.push_back(rnd_bf16());
      model();
      send_frame(int'($urandom_range(0, 3)));
      wait_valid();
      tick(int'($urandom_range(0, 3)));
      finish_hs();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
